// File: rtl/patch_tap_pkg.sv
// patch_tap_pkg: shared enums and register map for the patch observe/control tap
package patch_tap_pkg;
  typedef enum logic [1:0] {BYPASS, FORCE, INVERT, XOR} mode_e;
  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, DONE} state_e;
  localparam logic [2:0] ADDR_MATCH = 3'd0;
  localparam logic [2:0] ADDR_MASK  = 3'd1;
  localparam logic [2:0] ADDR_FORCE = 3'd2;
  localparam logic [2:0] ADDR_CTRL  = 3'd3;
  localparam logic [2:0] ADDR_HOLD  = 3'd4;
  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_ARM      = 2;
  localparam int CTRL_CLR      = 3;
endpackage

// File: rtl/patch_tap_chan.sv
// patch_tap_chan: one tap channel with registers, masked compare, arm/hold FSM and override mux
module patch_tap_chan
  import patch_tap_pkg::*;
#(
  parameter int W      = 8,
  parameter int HOLD_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [2:0]    addr,
  input  logic [15:0]   data,
  input  logic [W-1:0]  obs,
  input  logic [W-1:0]  ctl_in,
  output logic [W-1:0]  ctl_out,
  output logic          active,
  output logic          fired
);
  logic [W-1:0] match, mask, frc;
  logic [HOLD_W-1:0] hold, cnt;
  mode_e mode;
  state_e state, state_nx;
  logic wr_ctrl, hit, expire, unused;
  assign unused = ^data;
  assign wr_ctrl = wr && addr == ADDR_CTRL;
  assign hit = (obs & mask) == (match & mask);
  assign expire = state == ACTIVE && cnt == HOLD_W'(1);
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = (wr_ctrl && !data[CTRL_ARM])                      ? IDLE   :
               (wr_ctrl && (state == IDLE || state == DONE))     ? ARMED  :
               (state == ARMED && hit)                           ? ACTIVE :
               expire                                            ? DONE   : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match <= '0;
      mask  <= '0;
      frc   <= '0;
      hold  <= '0;
      mode  <= BYPASS;
      cnt   <= '0;
      fired <= 1'b0;
    end else begin
      if (wr && addr == ADDR_MATCH) match <= data[W-1:0];
      if (wr && addr == ADDR_MASK) mask <= data[W-1:0];
      if (wr && addr == ADDR_FORCE) frc <= data[W-1:0];
      if (wr && addr == ADDR_HOLD) hold <= data[HOLD_W-1:0];
      if (wr_ctrl) mode <= mode_e'(data[CTRL_MODE_LSB +: 2]);
      if (state == ARMED && state_nx == ACTIVE) cnt <= hold;
      else if (state == ACTIVE && cnt != '0) cnt <= cnt - HOLD_W'(1);
      fired <= (state == ACTIVE && state_nx == DONE) ? 1'b1 : (wr_ctrl && data[CTRL_CLR]) ? 1'b0 : fired;
    end
  end
  always_comb begin
    active  = state == ACTIVE;
    ctl_out = !active        ? ctl_in        :
              mode == FORCE  ? frc           :
              mode == INVERT ? ~ctl_in       :
              mode == XOR    ? ctl_in ^ frc  : ctl_in;
  end
endmodule

// File: rtl/patch_ctrl_tap.sv
// patch_ctrl_tap: multi-channel observe/control tap; decodes config writes and slices channel groups
module patch_ctrl_tap
  import patch_tap_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int W      = 8,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*W-1:0]  obs_in,
  input  logic [NCH*W-1:0]  ctl_in,
  output logic [NCH*W-1:0]  ctl_out,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic [2:0]        cfg_addr,
  input  logic [15:0]       cfg_data,
  output logic [NCH-1:0]    active,
  output logic [NCH-1:0]    fired
);
  assign cfg_ready = rst_n;
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    patch_tap_chan #(.W(W), .HOLD_W(HOLD_W)) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (cfg_valid && cfg_ready && cfg_ch == 4'(c)),
      .addr    (cfg_addr),
      .data    (cfg_data),
      .obs     (obs_in[c*W +: W]),
      .ctl_in  (ctl_in[c*W +: W]),
      .ctl_out (ctl_out[c*W +: W]),
      .active  (active[c]),
      .fired   (fired[c])
    );
  end
endmodule

// File: tb/tb_patch_ctrl_tap.sv
// tb_patch_ctrl_tap: directed scoreboard bench for patch_ctrl_tap
module tb_patch_ctrl_tap;
  localparam logic [31:0] CI = 32'h7E5A_C3A5;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] obs_in, ctl_in, ctl_out;
  logic cfg_valid, cfg_ready;
  logic [3:0] cfg_ch;
  logic [2:0] cfg_addr;
  logic [15:0] cfg_data;
  logic [3:0] active, fired;
  typedef struct packed {
    logic [31:0] o;
    logic [3:0] a;
    logic [3:0] f;
    logic r;
  } exp_t;
  exp_t eq[$];
  string nq[$];
  int checks = 0;
  int errors = 0;
  patch_ctrl_tap #(.NCH(4), .W(8), .HOLD_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .obs_in    (obs_in),
    .ctl_in    (ctl_in),
    .ctl_out   (ctl_out),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .active    (active),
    .fired     (fired)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (eq.size() > 0) begin
      exp_t e;
      string nm;
      e = eq.pop_front();
      nm = nq.pop_front();
      checks++;
      if ({ctl_out, active, fired, cfg_ready} !== {e.o, e.a, e.f, e.r}) begin
        errors++;
        $display("FAIL %s: got ctl_out=%h active=%b fired=%b ready=%b, want ctl_out=%h active=%b fired=%b ready=%b",
                 nm, ctl_out, active, fired, cfg_ready, e.o, e.a, e.f, e.r);
      end
    end
  end
  task automatic cyc(input logic [3:0] ch, input logic [2:0] a, input logic [15:0] d);
    cfg_valid = 1'b1;
    cfg_ch = ch;
    cfg_addr = a;
    cfg_data = d;
  endtask
  task automatic chk(input string nm, input logic [31:0] o, input logic [3:0] a, input logic [3:0] f, input logic r);
    eq.push_back('{o: o, a: a, f: f, r: r});
    nq.push_back(nm);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask
  task automatic wr(input logic [3:0] ch, input logic [2:0] a, input logic [15:0] d);
    cyc(ch, a, d);
    step();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    obs_in = 32'h1234_5678;
    ctl_in = CI;
    cfg_valid = 1'b0;
    cfg_ch = '0;
    cfg_addr = '0;
    cfg_data = '0;
    step();
    chk("reset", CI, 4'b0000, 4'b0000, 1'b0);
    step();
    obs_in = 32'hFFFF_FFFF;
    chk("reset_obs", CI, 4'b0000, 4'b0000, 1'b0);
    step();
    rst_n = 1'b1;
    obs_in = '0;
    chk("reset_release", CI, 4'b0000, 4'b0000, 1'b1);
    step();
    wr(0, 3'd0, 16'h003C);
    wr(0, 3'd1, 16'h00FF);
    wr(0, 3'd2, 16'h0000);
    wr(0, 3'd4, 16'h0003);
    wr(0, 3'd3, 16'h0005);
    chk("ch0_armed", CI, 4'b0000, 4'b0000, 1'b1);
    step();
    obs_in = 32'h0000_003C;
    chk("ch0_match", CI, 4'b0000, 4'b0000, 1'b1);
    step();
    obs_in = '0;
    for (int i = 0; i < 3; i++) begin
      chk("ch0_force", 32'h7E5A_C300, 4'b0001, 4'b0000, 1'b1);
      step();
    end
    chk("ch0_done", CI, 4'b0000, 4'b0001, 1'b1);
    step();
    wr(0, 3'd3, 16'h0005);
    obs_in = 32'h0000_003C;
    chk("ch0_rearm_match", CI, 4'b0000, 4'b0001, 1'b1);
    step();
    obs_in = '0;
    chk("ch0_rearm_force", 32'h7E5A_C300, 4'b0001, 4'b0001, 1'b1);
    step();
    step();
    step();
    chk("ch0_rearm_done", CI, 4'b0000, 4'b0001, 1'b1);
    step();
    wr(0, 3'd3, 16'h0008);
    chk("ch0_clr_fired", CI, 4'b0000, 4'b0000, 1'b1);
    step();
    wr(0, 3'd4, 16'h0001);
    wr(0, 3'd3, 16'h0005);
    obs_in = 32'h0000_003C;
    step();
    obs_in = '0;
    cyc(0, 3'd3, 16'h000D);
    chk("clr_set_active", 32'h7E5A_C300, 4'b0001, 4'b0000, 1'b1);
    step();
    chk("clr_set_wins", CI, 4'b0000, 4'b0001, 1'b1);
    step();
    wr(2, 3'd1, 16'h000F);
    wr(2, 3'd0, 16'h0005);
    wr(2, 3'd3, 16'h0006);
    obs_in = 32'h00F5_0000;
    chk("ch2_match", CI, 4'b0000, 4'b0001, 1'b1);
    step();
    obs_in = '0;
    for (int i = 0; i < 4; i++) begin
      chk("ch2_invert", 32'h7EA5_C3A5, 4'b0100, 4'b0001, 1'b1);
      step();
    end
    ctl_in = 32'h0011_2233;
    chk("ch2_invert_ctl", 32'h00EE_2233, 4'b0100, 4'b0001, 1'b1);
    step();
    ctl_in = CI;
    cyc(2, 3'd3, 16'h0002);
    chk("ch2_disarm_cycle", 32'h7EA5_C3A5, 4'b0100, 4'b0001, 1'b1);
    step();
    chk("ch2_passthrough", CI, 4'b0000, 4'b0001, 1'b1);
    step();
    wr(1, 3'd2, 16'h0011);
    wr(1, 3'd4, 16'h0002);
    wr(1, 3'd3, 16'h0005);
    cyc(1, 3'd3, 16'h0001);
    chk("ch1_disarm_match", CI, 4'b0000, 4'b0001, 1'b1);
    step();
    for (int i = 0; i < 2; i++) begin
      chk("ch1_stays_idle", CI, 4'b0000, 4'b0001, 1'b1);
      step();
    end
    for (int k = 0; k < 2; k++) begin
      wr(1, 3'd3, 16'h0005);
      chk("ch1_armed", CI, 4'b0000, k == 0 ? 4'b0001 : 4'b0011, 1'b1);
      step();
      for (int i = 0; i < 2; i++) begin
        chk("ch1_force", 32'h7E5A_11A5, 4'b0010, k == 0 ? 4'b0001 : 4'b0011, 1'b1);
        step();
      end
      chk("ch1_done", CI, 4'b0000, 4'b0011, 1'b1);
      step();
    end
    wr(3, 3'd2, 16'h00FF);
    wr(3, 3'd4, 16'h0002);
    wr(3, 3'd1, 16'h00FF);
    wr(3, 3'd0, 16'h0042);
    wr(3, 3'd3, 16'h0007);
    obs_in = 32'h4200_0000;
    chk("ch3_match", CI, 4'b0000, 4'b0011, 1'b1);
    step();
    obs_in = '0;
    rst_n = 1'b0;
    chk("ch3_xor_in_reset", 32'h815A_C3A5, 4'b1000, 4'b0011, 1'b0);
    step();
    chk("ch3_reset_idle", CI, 4'b0000, 4'b0000, 1'b0);
    step();
    rst_n = 1'b1;
    chk("reset_release2", CI, 4'b0000, 4'b0000, 1'b1);
    step();
    wr(3, 3'd3, 16'h0007);
    chk("zero_regs_armed", CI, 4'b0000, 4'b0000, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("zero_regs_active", CI, 4'b1000, 4'b0000, 1'b1);
      step();
    end
    wr(3, 3'd3, 16'h0000);
    chk("ch3_disarmed", CI, 4'b0000, 4'b0000, 1'b1);
    step();
    wr(5, 3'd3, 16'h0005);
    wr(5, 3'd1, 16'h00FF);
    wr(0, 3'd6, 16'hFFFF);
    step();
    chk("ignored_writes", CI, 4'b0000, 4'b0000, 1'b1);
    step();
    wr(0, 3'd3, 16'h0005);
    chk("ch0_armed_zero", CI, 4'b0000, 4'b0000, 1'b1);
    step();
    chk("ch0_force_zero", 32'h7E5A_C300, 4'b0001, 4'b0000, 1'b1);
    step();
    wr(0, 3'd3, 16'h0000);
    chk("ch0_final_idle", CI, 4'b0000, 4'b0000, 1'b1);
    step();
    step();
    if (eq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", eq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
